// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS channel encoder:
// control tokens, latency figures and the q_m transition-minimising stage.
package tmds_pkg;

    localparam int TMDS_LATENCY_PIPE   = 2;
    localparam int TMDS_LATENCY_NOPIPE = 1;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    function automatic logic [9:0] tmds_ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            default: tok = TMDS_CTRL_11;
        endcase
        return tok;
    endfunction

    // XNOR chaining when the byte is one-heavy (ties broken by bit 0), else XOR.
    function automatic logic [8:0] tmds_build_qm(input logic [7:0] d, input logic [3:0] n1);
        logic       use_xnor;
        logic [8:0] qm;
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Number of set bits in an 8-bit word (0..8).
module tmds_popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, data_i[i]};
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: 8b/10b video encoding with running DC balance, plus
// control-token insertion during blanking. One symbol per pixel clock.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int C_pipeline = 1
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic [1:0] in_c,
    input  logic       in_blank,
    output logic [9:0] out_tmds
);

    logic [7:0] data_s_q;
    logic [1:0] c_s_q;
    logic       blank_s_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            data_s_q  <= '0;
            c_s_q     <= 2'b00;
            blank_s_q <= 1'b1;
        end else begin
            data_s_q  <= in_data;
            c_s_q     <= in_c;
            blank_s_q <= in_blank;
        end
    end

    logic [3:0] n1;
    logic [8:0] qm_s;

    tmds_popcount8 u_pop_data (
        .data_i  (data_s_q),
        .count_o (n1)
    );

    assign qm_s = tmds_build_qm(data_s_q, n1);

    // Blank and control bits travel with q_m so the output stage sees aligned data.
    logic [8:0] qm_m;
    logic [1:0] c_m;
    logic       blank_m;

    generate
        if (C_pipeline != 0) begin : g_qm_reg
            logic [8:0] qm_m_q;
            logic [1:0] c_m_q;
            logic       blank_m_q;

            always_ff @(posedge clk_pixel) begin
                if (reset) begin
                    qm_m_q    <= '0;
                    c_m_q     <= 2'b00;
                    blank_m_q <= 1'b1;
                end else begin
                    qm_m_q    <= qm_s;
                    c_m_q     <= c_s_q;
                    blank_m_q <= blank_s_q;
                end
            end

            assign qm_m    = qm_m_q;
            assign c_m     = c_m_q;
            assign blank_m = blank_m_q;
        end else begin : g_qm_comb
            assign qm_m    = qm_s;
            assign c_m     = c_s_q;
            assign blank_m = blank_s_q;
        end
    endgenerate

    logic [3:0]        n1_qm;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q, cnt_d;
    logic [9:0]        tmds_q, tmds_d;

    tmds_popcount8 u_pop_qm (
        .data_i  (qm_m[7:0]),
        .count_o (n1_qm)
    );

    // diff = N1 - N0 of q_m[7:0], i.e. 2*N1 - 8.
    assign diff = $signed({n1_qm, 1'b0}) - 5'sd8;

    always_comb begin
        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (blank_m) begin
            tmds_d = tmds_ctrl_token(c_m);
            cnt_d  = 5'sd0;
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            tmds_d = {~qm_m[8], qm_m[8], qm_m[8] ? qm_m[7:0] : ~qm_m[7:0]};
            cnt_d  = qm_m[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            tmds_d = {1'b1, qm_m[8], ~qm_m[7:0]};
            cnt_d  = cnt_q + (qm_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            tmds_d = {1'b0, qm_m[8], qm_m[7:0]};
            cnt_d  = cnt_q - (qm_m[8] ? 5'sd0 : 5'sd2) + diff;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            tmds_q <= TMDS_CTRL_00;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_tmds = tmds_q;

endmodule

// File: doc/tmds_channel_encoder.md
TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

Interface
REQ-001 SHALL have parameter C_pipeline, default 1: 1 gives 2-cycle latency with a registered q_m stage; 0 gives 1-cycle latency.
REQ-002 SHALL have port clk_pixel, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8 bits: pixel colour component, sampled when in_blank=0.
REQ-005 SHALL have port in_c, input, 2 bits: control pair, with c0=hsync and c1=vsync on the blue channel, sampled when in_blank=1.
REQ-006 SHALL have port in_blank, input, 1 bit: 1 selects the control period, 0 selects the video period.
REQ-007 SHALL have port out_tmds, output, 10 bits: encoded symbol, registered; bit 0 is transmitted first.

Function
REQ-008 SHALL sample in_data, in_c and in_blank on every clk_pixel edge; there is no handshake and one symbol is produced per clock.
REQ-009 SHALL present the symbol for inputs sampled at edge k on out_tmds after edge k+2 when C_pipeline=1, and after edge k+1 when C_pipeline=0.
REQ-010 SHALL compute n1 as the popcount of in_data, range 0..8, 4 bits.
REQ-011 SHALL build q_m using XNOR chaining with q_m[8]=0 if n1>4, or if n1==4 and in_data[0]==0; otherwise it SHALL use XOR chaining with q_m[8]=1. In both cases q_m[0]=in_data[0].
REQ-012 SHALL keep a running disparity cnt as a 5-bit signed register covering -16..+15; the legal reachable range is -8..+8, always even.
REQ-013 SHALL, if cnt==0 or N1(q_m[7:0])==N0(q_m[7:0]), output {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}, then update cnt by +(N1-N0) if q_m[8]=1 and by +(N0-N1) if q_m[8]=0.
REQ-014 SHALL, else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1), output {1, q_m[8], ~q_m[7:0]}, then update cnt by 2*q_m[8] + (N0-N1).
REQ-015 SHALL, otherwise, output {0, q_m[8], q_m[7:0]}, then update cnt by -2*(~q_m[8]) + (N1-N0).
REQ-016 SHALL, in the control period, output in_c=00 as 1101010100, 01 as 0010101011, 10 as 0101010100 and 11 as 1010101011, and force cnt to 0.
REQ-017 SHALL delay in_blank and in_c alongside q_m through the pipeline, so that the control/video decision is made on aligned data.
REQ-018 SHALL, on a blank to video transition, compute the first video symbol with cnt=0.
REQ-019 SHALL perform all disparity arithmetic at signed 5-bit width with no saturation; overflow is unreachable for legal operation.

Reset
REQ-020 SHALL, while reset=1 at an edge, set out_tmds to 1101010100 and cnt to 0, and clear all pipeline registers to the blank=1, c=00 state.
REQ-021 SHALL, after reset is released, emit control token 00 until the first sampled input reaches the output, which is 2 edges later when C_pipeline=1.
REQ-022 SHALL treat a reset asserted mid-stream as overriding all other behaviour on that edge, with no partial symbols.

Structure
REQ-023 SHALL place the four control-token constants and the C_pipeline latency constants in a shared package, tmds_pkg.
REQ-024 SHALL implement the 8-bit popcount as one sub-module, tmds_popcount8, instantiated for n1 and for N1(q_m[7:0]).
REQ-025 SHALL be instantiated three times per video output (red, green, blue); in_c is tied to 00 on the red and green channels.

Verification
REQ-026 Bench SHALL hold reset=1 for 3 cycles -> out_tmds=1101010100 throughout and for 2 cycles after release.
REQ-027 Bench SHALL apply in_blank=1 with in_c=00,01,10,11 -> after 2 cycles, 1101010100, 0010101011, 0101010100, 1010101011 in order.
REQ-028 Bench SHALL apply in_blank=0 with in_data=0x00 twice from cnt=0 -> 0100000000 (cnt=-8), then 1111111111 (cnt=+2).
REQ-029 Bench SHALL apply a long run of in_data=0x00, then in_blank=1, then 0x00 -> the first post-blank symbol is 0100000000 (cnt was forced to 0).
REQ-030 Bench SHALL apply 10000 random video bytes -> a reference model matches every symbol, cnt stays within -8..+8, and a software TMDS decode returns the original bytes.
REQ-031 Bench SHALL assert reset while in mid video -> the next output is 1101010100 and the decode of post-reset data matches from cnt=0.
